// File: rtl/color_frame_classifier.sv
// Per-frame colour pixel counter and debounced frame classifier.
// Counts red/green/black pixels per frame, classifies each frame and commits a colour after a run of agreeing frames.
module color_frame_classifier #(
    parameter int CNT_W          = 19,
    parameter int MIN_PIXELS     = 2000,
    parameter int CONFIRM_FRAMES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pix_valid,
    input  logic             sof,
    input  logic             eof,
    input  logic             is_red,
    input  logic             is_green,
    input  logic             is_black,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             frame_done,
    output logic [1:0]       color_code,
    output logic             color_changed,
    output logic             frame_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [31:0]      MIN_P   = 32'(MIN_PIXELS);
    localparam logic [3:0]       CONF    = 4'(CONFIRM_FRAMES);

    state_t           state, state_next;
    logic             clear, count, err_next;
    logic [CNT_W-1:0] r_acc, g_acc, b_acc;
    logic [CNT_W-1:0] r_base, g_base, b_base;
    logic [CNT_W-1:0] r_next, g_next, b_next;
    logic [31:0]      r_ext, g_ext, b_ext;
    logic [1:0]       prev_cand, cand;
    logic [3:0]       streak, streak_next;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        count      = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && pix_valid && sof) begin
                    clear      = 1'b1;
                    count      = 1'b1;
                    state_next = eof ? DECIDE : ACCUM;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (pix_valid) begin
                    count = 1'b1;
                    // A new sof restarts the frame on this very pixel.
                    if (sof) begin
                        clear    = 1'b1;
                        err_next = !eof;
                    end
                    if (eof) state_next = DECIDE;
                end
            end
            DECIDE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        r_base = clear ? '0 : r_acc;
        g_base = clear ? '0 : g_acc;
        b_base = clear ? '0 : b_acc;
        r_next = r_base;
        g_next = g_base;
        b_next = b_base;
        if (count) begin
            if (is_red) begin
                if (r_base != CNT_MAX) r_next = r_base + CNT_ONE;
            end else if (is_green) begin
                if (g_base != CNT_MAX) g_next = g_base + CNT_ONE;
            end else if (is_black) begin
                if (b_base != CNT_MAX) b_next = b_base + CNT_ONE;
            end
        end
    end

    // Candidate for the frame just closed; a red/green tie falls through to black/none.
    always_comb begin
        r_ext = 32'(r_acc);
        g_ext = 32'(g_acc);
        b_ext = 32'(b_acc);
        if (r_ext >= MIN_P && r_acc > g_acc)      cand = 2'd1;
        else if (g_ext >= MIN_P && g_acc > r_acc) cand = 2'd2;
        else if (b_ext >= MIN_P)                  cand = 2'd3;
        else                                      cand = 2'd0;

        if (cand == prev_cand) streak_next = (streak >= CONF) ? CONF : streak + 4'd1;
        else                   streak_next = 4'd1;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            r_acc         <= '0;
            g_acc         <= '0;
            b_acc         <= '0;
            red_cnt       <= '0;
            green_cnt     <= '0;
            blk_cnt       <= '0;
            prev_cand     <= 2'd0;
            streak        <= 4'd0;
            color_code    <= 2'd0;
            frame_done    <= 1'b0;
            color_changed <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state         <= state_next;
            r_acc         <= r_next;
            g_acc         <= g_next;
            b_acc         <= b_next;
            frame_err     <= err_next;
            frame_done    <= (state == DECIDE);
            color_changed <= 1'b0;
            if (state == DECIDE) begin
                red_cnt   <= r_acc;
                green_cnt <= g_acc;
                blk_cnt   <= b_acc;
                prev_cand <= cand;
                streak    <= streak_next;
                if (streak_next >= CONF) begin
                    color_code    <= cand;
                    color_changed <= (cand != color_code);
                end
            end
        end
    end

endmodule

// File: tb/tb_color_frame_classifier.sv
// Self-checking bench for color_frame_classifier: directed scenarios plus random frames
// compared against a frame-level reference model (counts, candidate history, commit rule).
module tb_color_frame_classifier;

    localparam int CNT_W          = 3;
    localparam int MIN_PIXELS     = 4;
    localparam int CONFIRM_FRAMES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic pix_valid = 1'b0;
    logic sof = 1'b0;
    logic eof = 1'b0;
    logic is_red = 1'b0;
    logic is_green = 1'b0;
    logic is_black = 1'b0;
    logic [CNT_W-1:0] red_cnt, green_cnt, blk_cnt;
    logic             frame_done, color_changed, frame_err;
    logic [1:0]       color_code;

    int n_checks = 0;
    int n_errors = 0;
    int done_count = 0;
    int chg_count = 0;
    int err_count = 0;

    // Frame pixels as {red, green, black} flags.
    logic [2:0] frame_q[$];
    int         hist[$];
    logic [1:0] m_code = 2'd0;
    logic [CNT_W-1:0] exp_r, exp_g, exp_b;
    logic [1:0] exp_code;
    logic       exp_changed;

    color_frame_classifier #(
        .CNT_W(CNT_W),
        .MIN_PIXELS(MIN_PIXELS),
        .CONFIRM_FRAMES(CONFIRM_FRAMES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .pix_valid(pix_valid),
        .sof(sof),
        .eof(eof),
        .is_red(is_red),
        .is_green(is_green),
        .is_black(is_black),
        .red_cnt(red_cnt),
        .green_cnt(green_cnt),
        .blk_cnt(blk_cnt),
        .frame_done(frame_done),
        .color_code(color_code),
        .color_changed(color_changed),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1)    done_count++;
        if (color_changed === 1'b1) chg_count++;
        if (frame_err === 1'b1)     err_count++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: saturated priority counts, candidate rule, commit after CONFIRM_FRAMES equal candidates.
    function automatic void model_frame();
        int r, g, b, sat, cand;
        bit commit;
        r = 0; g = 0; b = 0;
        sat = (1 << CNT_W) - 1;
        foreach (frame_q[i]) begin
            if (frame_q[i][2])      r++;
            else if (frame_q[i][1]) g++;
            else if (frame_q[i][0]) b++;
        end
        if (r > sat) r = sat;
        if (g > sat) g = sat;
        if (b > sat) b = sat;
        if (r >= MIN_PIXELS && r > g)      cand = 1;
        else if (g >= MIN_PIXELS && g > r) cand = 2;
        else if (b >= MIN_PIXELS)          cand = 3;
        else                               cand = 0;
        hist.push_back(cand);
        commit = (hist.size() >= CONFIRM_FRAMES);
        for (int k = 1; k < CONFIRM_FRAMES; k++)
            if (commit && hist[hist.size() - 1 - k] != cand) commit = 1'b0;
        exp_changed = 1'b0;
        if (commit) begin
            exp_changed = (2'(cand) != m_code);
            m_code      = 2'(cand);
        end
        exp_code = m_code;
        exp_r    = CNT_W'(r);
        exp_g    = CNT_W'(g);
        exp_b    = CNT_W'(b);
    endfunction

    task automatic shuffle_frame();
        for (int i = frame_q.size() - 1; i > 0; i--) begin
            int j;
            logic [2:0] t;
            j = int'($urandom_range(0, i));
            t = frame_q[i];
            frame_q[i] = frame_q[j];
            frame_q[j] = t;
        end
    endtask

    task automatic make_frame(input int nr, input int ng, input int nb, input int nn);
        frame_q.delete();
        repeat (nr) frame_q.push_back(3'b100);
        repeat (ng) frame_q.push_back(3'b010);
        repeat (nb) frame_q.push_back(3'b001);
        repeat (nn) frame_q.push_back(3'b000);
        shuffle_frame();
    endtask

    task automatic make_random_frame(input int n);
        int dom;
        dom = int'($urandom_range(0, 3));
        frame_q.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1)
                frame_q.push_back(dom == 1 ? 3'b100 : dom == 2 ? 3'b010 : dom == 3 ? 3'b001 : 3'b000);
            else
                frame_q.push_back(3'($urandom_range(0, 7)));
        end
    endtask

    task automatic drive_pixel(input logic [2:0] flags, input logic s, input logic e);
        pix_valid = 1'b1;
        sof       = s;
        eof       = e;
        {is_red, is_green, is_black} = flags;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pix_valid = 1'b0;
        sof       = 1'b0;
        eof       = 1'b0;
        {is_red, is_green, is_black} = 3'b000;
    endtask

    // Idle cycle carrying junk markers and flags that must be ignored without pix_valid.
    task automatic maybe_gap(input bit gaps);
        if (gaps && $urandom_range(0, 3) == 0) begin
            pix_valid = 1'b0;
            sof       = 1'($urandom_range(0, 1));
            eof       = 1'($urandom_range(0, 1));
            {is_red, is_green, is_black} = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
    endtask

    // Optional 'prefix' junk pixels open a frame that the real frame's sof then restarts.
    task automatic run_frame(input int prefix, input bit gaps, input string tag);
        int d0, c0, e0, exp_err;
        d0 = done_count; c0 = chg_count; e0 = err_count;
        exp_err = (prefix > 0) ? 1 : 0;
        for (int i = 0; i < prefix; i++) begin
            maybe_gap(gaps);
            drive_pixel(3'($urandom_range(0, 7)), i == 0, 1'b0);
        end
        for (int i = 0; i < frame_q.size(); i++) begin
            maybe_gap(gaps);
            drive_pixel(frame_q[i], i == 0, i == frame_q.size() - 1);
        end
        idle_inputs();
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s done_early: frame_done=%b expected 0 one cycle after eof", tag, frame_done);
        end
        @(posedge clk);
        #1;
        model_frame();
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s done_pulse: frame_done=%b expected 1 at eof+2", tag, frame_done);
        end
        n_checks++;
        if (red_cnt !== exp_r || green_cnt !== exp_g || blk_cnt !== exp_b) begin
            n_errors++;
            $display("FAIL %s counts: got r=%0d g=%0d b=%0d expected r=%0d g=%0d b=%0d",
                     tag, red_cnt, green_cnt, blk_cnt, exp_r, exp_g, exp_b);
        end
        n_checks++;
        if (color_code !== exp_code) begin
            n_errors++;
            $display("FAIL %s color_code: got %0d expected %0d", tag, color_code, exp_code);
        end
        n_checks++;
        if (color_changed !== exp_changed) begin
            n_errors++;
            $display("FAIL %s color_changed: got %b expected %b", tag, color_changed, exp_changed);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done_count != d0 + 1 || chg_count != c0 + int'(exp_changed) || err_count != e0 + exp_err) begin
            n_errors++;
            $display("FAIL %s pulse_counts: done=%0d chg=%0d err=%0d expected done=%0d chg=%0d err=%0d",
                     tag, done_count - d0, chg_count - c0, err_count - e0, 1, int'(exp_changed), exp_err);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if (red_cnt !== '0 || green_cnt !== '0 || blk_cnt !== '0 || color_code !== 2'd0 ||
            frame_done !== 1'b0 || color_changed !== 1'b0 || frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL %s: got r=%0d g=%0d b=%0d code=%0d done=%b chg=%b err=%b expected all 0",
                     tag, red_cnt, green_cnt, blk_cnt, color_code, frame_done, color_changed, frame_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        check_all_zero("reset_state");
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("after_release");
        hist.delete();
        m_code = 2'd0;
    endtask

    task automatic test_red_confirm();
        make_frame(6, 2, 0, 2);
        run_frame(0, 1'b0, "red_frame1");
        make_frame(6, 2, 0, 2);
        run_frame(0, 1'b0, "red_frame2");
    endtask

    task automatic test_alternate();
        int c0;
        c0 = chg_count;
        make_frame(1, 5, 0, 0);
        run_frame(0, 1'b1, "alt_green");
        make_frame(5, 1, 0, 1);
        run_frame(0, 1'b1, "alt_red");
        make_frame(0, 6, 1, 0);
        run_frame(0, 1'b1, "alt_green2");
        n_checks++;
        if (chg_count != c0) begin
            n_errors++;
            $display("FAIL alt_no_change: color_changed pulses=%0d expected 0", chg_count - c0);
        end
    endtask

    task automatic test_tie_black();
        make_frame(5, 5, 4, 1);
        run_frame(0, 1'b0, "tie_frame1");
        make_frame(5, 5, 4, 0);
        run_frame(0, 1'b0, "tie_frame2");
    endtask

    task automatic test_frame_err();
        make_frame(2, 4, 1, 1);
        run_frame(4, 1'b0, "sof_restart");
    endtask

    task automatic test_saturation();
        make_frame(12, 0, 0, 0);
        run_frame(0, 1'b0, "sat_red");
    endtask

    task automatic test_enable_abort();
        int d0, e0;
        d0 = done_count; e0 = err_count;
        drive_pixel(3'b010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive_pixel(3'b010, 1'b0, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) drive_pixel(3'($urandom_range(0, 7)), 1'b0, 1'b0);
        idle_inputs();
        enable = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (done_count != d0 || err_count != e0) begin
            n_errors++;
            $display("FAIL abort_quiet: done=%0d err=%0d expected 0 0", done_count - d0, err_count - e0);
        end
        make_frame(5, 0, 2, 1);
        run_frame(0, 1'b1, "after_abort");
    endtask

    task automatic test_missed_sof();
        int d0, e0;
        logic [2:0] b_q[$];
        make_frame(1, 5, 0, 1);
        for (int i = 0; i < 4; i++) b_q.push_back(3'b100);
        d0 = done_count; e0 = err_count;
        for (int i = 0; i < frame_q.size(); i++)
            drive_pixel(frame_q[i], i == 0, i == frame_q.size() - 1);
        // Second frame starts in the decide cycle and must be skipped entirely.
        for (int i = 0; i < b_q.size(); i++)
            drive_pixel(b_q[i], i == 0, i == b_q.size() - 1);
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        model_frame();
        n_checks++;
        if (done_count != d0 + 1 || err_count != e0) begin
            n_errors++;
            $display("FAIL missed_sof_pulses: done=%0d err=%0d expected 1 0", done_count - d0, err_count - e0);
        end
        n_checks++;
        if (red_cnt !== exp_r || green_cnt !== exp_g || blk_cnt !== exp_b || color_code !== exp_code) begin
            n_errors++;
            $display("FAIL missed_sof_result: got r=%0d g=%0d b=%0d code=%0d expected r=%0d g=%0d b=%0d code=%0d",
                     red_cnt, green_cnt, blk_cnt, color_code, exp_r, exp_g, exp_b, exp_code);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int n, prefix;
            n = int'($urandom_range(1, 14));
            prefix = (n > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
            make_random_frame(n);
            run_frame(prefix, 1'b1, $sformatf("rand%0d", f));
        end
    endtask

    task automatic test_async_reset();
        int d0, c0, e0;
        make_frame(5, 1, 0, 0);
        run_frame(0, 1'b0, "pre_rst1");
        make_frame(6, 0, 1, 0);
        run_frame(0, 1'b0, "pre_rst2");
        drive_pixel(3'b100, 1'b1, 1'b0);
        drive_pixel(3'b100, 1'b0, 1'b0);
        drive_pixel(3'b001, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        hist.delete();
        m_code = 2'd0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        d0 = done_count; c0 = chg_count; e0 = err_count;
        for (int i = 0; i < 3; i++) drive_pixel(3'b100, 1'b0, 1'b0);
        drive_pixel(3'b100, 1'b0, 1'b1);
        idle_inputs();
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (done_count != d0 || chg_count != c0 || err_count != e0) begin
            n_errors++;
            $display("FAIL release_quiet: done=%0d chg=%0d err=%0d expected 0 0 0",
                     done_count - d0, chg_count - c0, err_count - e0);
        end
        make_frame(6, 1, 0, 0);
        run_frame(0, 1'b0, "post_rst1");
        make_frame(7, 0, 0, 0);
        run_frame(0, 1'b0, "post_rst2");
    endtask

    initial begin
        test_reset();
        test_red_confirm();
        test_alternate();
        test_tie_black();
        test_frame_err();
        test_saturation();
        test_enable_abort();
        test_missed_sof();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/color_frame_classifier.md
COLOR_FRAME_CLASSIFIER -- requirements
Module: color_frame_classifier

Interface
REQ-001 The module SHALL have parameter CNT_W, default 19, giving the per-colour pixel counter width (covers 640x480).
REQ-002 The module SHALL have parameter MIN_PIXELS, default 2000, giving the minimum per-colour count for a frame to be classified as that colour.
REQ-003 The module SHALL have parameter CONFIRM_FRAMES, default 3, giving the number of consecutive identical frame results required to commit them (range 1-15).
REQ-004 The module SHALL have port clk, input, 1 bit, the single system clock.
REQ-005 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The module SHALL have port enable, input, 1 bit, which runs classification while high.
REQ-007 The module SHALL have port pix_valid, input, 1 bit, which qualifies the per-pixel inputs for the current cycle.
REQ-008 The module SHALL have ports sof and eof, input, 1 bit each, marking the first and last pixel of a frame (meaningful only with pix_valid).
REQ-009 The module SHALL have ports is_red, is_green and is_black, input, 1 bit each, carrying one-hot-or-zero pixel colour flags from the HSV detector.
REQ-010 The module SHALL have ports red_cnt, green_cnt and blk_cnt, output, CNT_W bits each, holding the latched counts of the last completed frame.
REQ-011 The module SHALL have port frame_done, output, 1 bit, a one-cycle pulse when the counts are updated.
REQ-012 The module SHALL have port color_code, output, 2 bits, holding the committed colour: 0 none, 1 red, 2 green, 3 black.
REQ-013 The module SHALL have port color_changed, output, 1 bit, a one-cycle pulse when color_code changes.
REQ-014 The module SHALL have port frame_err, output, 1 bit, a one-cycle pulse when sof arrives mid-frame.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DECIDE.
REQ-016 IDLE SHALL go to ACCUM on enable&pix_valid&sof; that sof pixel SHALL be counted and all three accumulators SHALL be cleared to 0 before it is added.
REQ-017 In ACCUM, each pix_valid cycle SHALL add 1 to the accumulator of whichever flag is set, and no accumulator when no flag is set.
REQ-018 Accumulators SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-019 In ACCUM, pix_valid&eof SHALL count that pixel and enter DECIDE on the next cycle.
REQ-020 An eof pixel that also carries sof (1-pixel frame) SHALL be counted and SHALL go directly to DECIDE.
REQ-021 In ACCUM, pix_valid&sof without eof SHALL pulse frame_err, discard the partial frame and restart accumulation with that pixel; no decision SHALL be made for the discarded frame.
REQ-022 DECIDE SHALL last exactly one cycle and then return to IDLE; pixel inputs arriving during DECIDE SHALL be ignored, so sof in DECIDE is missed and that frame is skipped.
REQ-023 In DECIDE, the candidate result SHALL be red if r>=MIN_PIXELS and r>g; else green if g>=MIN_PIXELS and g>r; else black if b>=MIN_PIXELS; else none. A red/green tie SHALL fall through to the black/none checks.
REQ-024 In DECIDE, when candidate equals the previous candidate, the streak counter SHALL increment, saturating at CONFIRM_FRAMES; otherwise streak SHALL be set to 1 and the previous candidate SHALL be set to the new candidate.
REQ-025 When the updated streak is >= CONFIRM_FRAMES, color_code SHALL take the candidate value.
REQ-026 Outputs SHALL be registered: red_cnt, green_cnt, blk_cnt, frame_done, color_code and color_changed SHALL update on the clock edge that leaves DECIDE, i.e. eof+2 cycles.
REQ-027 color_changed SHALL pulse only if the new color_code differs from the old value.
REQ-028 enable low SHALL force IDLE within one cycle and discard any partial frame; color_code, the latched counts, the streak and the previous candidate SHALL be retained.
REQ-029 Inputs with multiple flags set SHALL count in priority red > green > black, matching the detector priority.

Reset
REQ-030 On rst_n low, asynchronously: state SHALL be IDLE; all accumulators and latched counts SHALL be 0; color_code SHALL be 0; the previous candidate SHALL be 0; streak SHALL be 0; all pulse outputs SHALL be 0.
REQ-031 Reset deassertion mid-frame SHALL wait for the next sof; no pulse SHALL be generated on reset release.

Verification
REQ-032 With MIN_PIXELS=4 and CONFIRM_FRAMES=2, two frames of 10 pixels each with 6 red and 2 green -> frame_done at eof+2 each frame; red_cnt=6; color_code=1 after frame 2 only; color_changed pulses once.
REQ-033 With MIN_PIXELS=4 and CONFIRM_FRAMES=2, after red is committed, frames green, red, green -> color_code stays 1 because streak resets each frame; no color_changed.
REQ-034 With MIN_PIXELS=4 and CONFIRM_FRAMES=2, r=g=5 and b=4 for two frames -> color_code=3 (tie falls through to black).
REQ-035 sof at pixel 5 of an open frame -> frame_err one pulse; counts restart; the following eof yields counts of the new frame only.
REQ-036 With CNT_W=3, 12 red pixels -> red_cnt=7 (saturated).
REQ-037 enable dropped mid-frame, then raised before the next sof -> no frame_done for the aborted frame; the next frame classifies normally.
REQ-038 rst_n pulsed during ACCUM -> all outputs are 0 immediately, with no clock edge required.
